rom_arbiter: RTL and testbench

Shares one single-port boot ROM (active-low chip enable, registered address, one-cycle read latency) between NUM_PORTS read requesters, such as core instruction fetch, the debug module and a DMA/bootloader master. Each requester port uses a request/grant/response-valid handshake. Requests are arbitrated round-robin. Writes and out-of-range addresses are filtered. Each response is routed back to its originating port, optionally through an output register stage.

---
 rtl/rom_arbiter.sv | 143 ++++++++++++++
 tb/tb_rom_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one single-port boot ROM between NUM_PORTS readers.
// Writes and out-of-window addresses get an error response with the same latency as a ROM read.
module rom_arbiter #(
   parameter int          NUM_PORTS  = 2,
   parameter int          ADDR_WIDTH = 10,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h1A00_0000,
   parameter int          RESP_REG   = 0
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [NUM_PORTS-1:0]    req_i,
   input  logic [NUM_PORTS-1:0]    we_i,
   input  logic [NUM_PORTS*32-1:0] addr_i,
   output logic [NUM_PORTS-1:0]    gnt_o,
   output logic [NUM_PORTS-1:0]    r_valid_o,
   output logic [NUM_PORTS-1:0]    r_err_o,
   output logic [DATA_WIDTH-1:0]   r_rdata_o,
   output logic                    rom_cen_o,
   output logic [ADDR_WIDTH-1:0]   rom_addr_o,
   input  logic [DATA_WIDTH-1:0]   rom_q_i
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [PW-1:0] rr_q, rr_d;
   logic [PW-1:0] gnt_idx;
   logic          gnt_any;
   logic          gnt_vld;
   logic          gnt_we;
   logic [31:0]   gnt_addr;
   logic          acc_ok;
   logic          unused_addr_bits;

   logic          v1_q, v1_d;
   logic [PW-1:0] port1_q, port1_d;
   logic          err1_q, err1_d;
   logic [DATA_WIDTH-1:0] data1;

   logic          v_sel;
   logic [PW-1:0] port_sel;
   logic          err_sel;
   logic [DATA_WIDTH-1:0] data_sel;
   logic          v_out;

   // Search starts at rr_q and wraps; the first requester found wins.
   always_comb begin
      int idx;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!gnt_any && req_i[PW'(idx)]) begin
            gnt_any = 1'b1;
            gnt_idx = PW'(idx);
         end
      end
   end

   assign gnt_vld          = RST_N & gnt_any;
   assign gnt_we           = we_i[gnt_idx];
   assign gnt_addr         = addr_i[gnt_idx*32 +: 32];
   assign unused_addr_bits = ^gnt_addr[1:0];
   assign acc_ok           = gnt_vld && !gnt_we &&
                             (gnt_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

   assign gnt_o      = gnt_vld ? (NUM_PORTS'(1) << gnt_idx) : '0;
   assign rom_cen_o  = !acc_ok;
   assign rom_addr_o = acc_ok ? gnt_addr[ADDR_WIDTH+1:2] : '0;

   always_comb begin
      rr_d    = rr_q;
      v1_d    = gnt_vld;
      port1_d = gnt_idx;
      err1_d  = gnt_vld && !acc_ok;
      if (gnt_vld) rr_d = (int'(gnt_idx) == NUM_PORTS-1) ? '0 : gnt_idx + PW'(1);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         rr_q    <= '0;
         v1_q    <= 1'b0;
         port1_q <= '0;
         err1_q  <= 1'b0;
      end else begin
         rr_q    <= rr_d;
         v1_q    <= v1_d;
         port1_q <= port1_d;
         err1_q  <= err1_d;
      end
   end

   // ROM data is valid exactly one cycle after an OK grant; error records never touched the ROM.
   assign data1 = err1_q ? '0 : rom_q_i;

   generate
      if (RESP_REG != 0) begin : g_resp_reg
         logic          v2_q, v2_d;
         logic [PW-1:0] port2_q, port2_d;
         logic          err2_q, err2_d;
         logic [DATA_WIDTH-1:0] data2_q, data2_d;

         always_comb begin
            v2_d    = v1_q;
            port2_d = port1_q;
            err2_d  = err1_q;
            data2_d = v1_q ? data1 : '0;
         end

         always_ff @(posedge CLK) begin
            if (!RST_N) begin
               v2_q    <= 1'b0;
               port2_q <= '0;
               err2_q  <= 1'b0;
               data2_q <= '0;
            end else begin
               v2_q    <= v2_d;
               port2_q <= port2_d;
               err2_q  <= err2_d;
               data2_q <= data2_d;
            end
         end

         assign v_sel    = v2_q;
         assign port_sel = port2_q;
         assign err_sel  = err2_q;
         assign data_sel = data2_q;
      end else begin : g_resp_comb
         assign v_sel    = v1_q;
         assign port_sel = port1_q;
         assign err_sel  = err1_q;
         assign data_sel = data1;
      end
   endgenerate

   assign v_out     = RST_N & v_sel;
   assign r_valid_o = v_out ? (NUM_PORTS'(1) << port_sel) : '0;
   assign r_err_o   = (v_out && err_sel) ? (NUM_PORTS'(1) << port_sel) : '0;
   assign r_rdata_o = v_out ? data_sel : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench: two arbiters (RESP_REG=0 and 1) driven by the same requesters, each with its own ROM model.
module tb_rom_arbiter;

   localparam logic [31:0] BASE = 32'h1A00_0000;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [1:0]  req, we;
   logic [63:0] addr;

   logic [1:0]  gnt0, rv0, re0, gnt1, rv1, re1;
   logic [31:0] rd0, rd1, q0, q1;
   logic        cen0, cen1;
   logic [9:0]  ra0, ra1;

   logic [31:0] mem [0:1023];
   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   rom_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(10), .DATA_WIDTH(32), .BASE_ADDR(BASE), .RESP_REG(0)) u_dut0 (
      .CLK(CLK), .RST_N(RST_N), .req_i(req), .we_i(we), .addr_i(addr),
      .gnt_o(gnt0), .r_valid_o(rv0), .r_err_o(re0), .r_rdata_o(rd0),
      .rom_cen_o(cen0), .rom_addr_o(ra0), .rom_q_i(q0));

   rom_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(10), .DATA_WIDTH(32), .BASE_ADDR(BASE), .RESP_REG(1)) u_dut1 (
      .CLK(CLK), .RST_N(RST_N), .req_i(req), .we_i(we), .addr_i(addr),
      .gnt_o(gnt1), .r_valid_o(rv1), .r_err_o(re1), .r_rdata_o(rd1),
      .rom_cen_o(cen1), .rom_addr_o(ra1), .rom_q_i(q1));

   always @(posedge CLK) begin
      if (!cen0) q0 <= mem[ra0];
      if (!cen1) q1 <= mem[ra1];
   end

   function automatic logic [31:0] word(input int i);
      return (i == 5) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i) * 32'h0001_0003;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then driven and outputs settle by +1.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = word(i);
      q0 = '0; q1 = '0;
      RST_N = 1'b0; req = 2'b11; we = 2'b00;
      addr = {BASE + 32'd28, BASE + 32'd12};

      // Reset holds all outputs quiet even with requests pending
      tick(); settle();
      chk("rst_gnt", 32'(gnt0), 32'd0);
      chk("rst_cen", 32'(cen0), 32'd1);
      chk("rst_valid", 32'(rv0), 32'd0);
      chk("rst_err", 32'(re0), 32'd0);
      chk("rst_rdata", rd0, 32'd0);
      chk("rst_valid_r1", 32'(rv1), 32'd0);
      tick();
      RST_N = 1'b1; req = 2'b00; settle();
      chk("idle_gnt", 32'(gnt0), 32'd0);
      chk("idle_cen", 32'(cen0), 32'd1);
      chk("idle_addr", 32'(ra0), 32'd0);

      // Single read of word 5 by port 0
      tick(); req = 2'b01; addr[31:0] = BASE + 32'd20; settle();
      chk("a_gnt", 32'(gnt0), 32'h1);
      chk("a_cen", 32'(cen0), 32'd0);
      chk("a_addr", 32'(ra0), 32'd5);
      tick(); req = 2'b00; settle();
      chk("a_valid", 32'(rv0), 32'h1);
      chk("a_rdata", rd0, 32'hDEAD_BEEF);
      chk("a_err", 32'(re0), 32'd0);
      chk("a_valid_r1_early", 32'(rv1), 32'd0);
      tick(); settle();
      chk("a_valid_r1", 32'(rv1), 32'h1);
      chk("a_rdata_r1", rd1, 32'hDEAD_BEEF);
      chk("a_valid_gone", 32'(rv0), 32'd0);
      chk("a_rdata_zero", rd0, 32'd0);

      // Reset again so both ports contend starting from rr=0
      tick(); RST_N = 1'b0; tick(); RST_N = 1'b1;
      addr = {BASE + 32'd28, BASE + 32'd12};
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         req = 2'b11; settle();
         chk($sformatf("b_gnt%0d", i), 32'(gnt0), (i % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("b_addr%0d", i), 32'(ra0), (i % 2 == 0) ? 32'd3 : 32'd7);
         if (i > 0) begin
            chk($sformatf("b_valid%0d", i), 32'(rv0), (i % 2 == 1) ? 32'h1 : 32'h2);
            chk($sformatf("b_rdata%0d", i), rd0, (i % 2 == 1) ? word(3) : word(7));
         end
      end
      tick(); req = 2'b00; settle();
      chk("b_valid_last", 32'(rv0), 32'h2);
      chk("b_rdata_last", rd0, word(7));

      // Port 1 write to ROM base: no ROM access, error response
      tick(); req = 2'b10; we = 2'b10; addr[63:32] = BASE; settle();
      chk("c_wr_gnt", 32'(gnt0), 32'h2);
      chk("c_wr_cen", 32'(cen0), 32'd1);
      chk("c_wr_addr", 32'(ra0), 32'd0);
      // Port 1 read just past the window
      tick(); we = 2'b00; addr[63:32] = BASE + 32'd4096; settle();
      chk("c_wr_valid", 32'(rv0), 32'h2);
      chk("c_wr_err", 32'(re0), 32'h2);
      chk("c_wr_rdata", rd0, 32'd0);
      chk("c_oor_gnt", 32'(gnt0), 32'h2);
      chk("c_oor_cen", 32'(cen0), 32'd1);
      tick(); req = 2'b11; addr = {BASE + 32'd28, BASE + 32'd12}; settle();
      chk("c_oor_valid", 32'(rv0), 32'h2);
      chk("c_oor_err", 32'(re0), 32'h2);
      chk("c_oor_rdata", rd0, 32'd0);
      chk("c_rr_gnt0", 32'(gnt0), 32'h1);
      tick(); settle();
      chk("c_rr_gnt1", 32'(gnt0), 32'h2);
      chk("c_ok_valid", 32'(rv0), 32'h1);
      chk("c_ok_err", 32'(re0), 32'd0);
      chk("c_ok_rdata", rd0, word(3));
      chk("c_r1_err", 32'(re1), 32'h2);
      tick(); req = 2'b00; settle();
      chk("c_ok_rdata2", rd0, word(7));
      tick(); tick();

      // Back-to-back reads of words 0,1,2 by port 0
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         req = 2'b01; addr[31:0] = BASE + 32'(4 * i); settle();
         chk($sformatf("d_gnt%0d", i), 32'(gnt0), 32'h1);
         if (i == 1) chk("d_r1_nolat", 32'(rv1), 32'd0);
         if (i > 0) chk($sformatf("d_rdata0_%0d", i), rd0, word(i - 1));
         if (i == 2) begin
            chk("d_r1_valid0", 32'(rv1), 32'h1);
            chk("d_r1_rdata0", rd1, word(0));
         end
      end
      tick(); req = 2'b00; settle();
      chk("d_r1_valid1", 32'(rv1), 32'h1);
      chk("d_r1_rdata1", rd1, word(1));
      tick(); settle();
      chk("d_r1_valid2", 32'(rv1), 32'h1);
      chk("d_r1_rdata2", rd1, word(2));
      tick(); settle();
      chk("d_r1_idle", 32'(rv1), 32'd0);

      // Reset right after a grant discards the in-flight response
      tick(); req = 2'b01; addr[31:0] = BASE + 32'd20; settle();
      chk("e_gnt", 32'(gnt0), 32'h1);
      tick(); RST_N = 1'b0; req = 2'b11; settle();
      chk("e_rst_valid", 32'(rv0), 32'd0);
      chk("e_rst_rdata", rd0, 32'd0);
      chk("e_rst_gnt", 32'(gnt0), 32'd0);
      chk("e_rst_cen", 32'(cen0), 32'd1);
      chk("e_rst_valid_r1", 32'(rv1), 32'd0);
      tick(); RST_N = 1'b1; req = 2'b00; settle();
      chk("e_post_valid", 32'(rv0), 32'd0);
      chk("e_post_valid_r1", 32'(rv1), 32'd0);
      tick(); settle();
      chk("e_post2_valid", 32'(rv0), 32'd0);
      chk("e_post2_valid_r1", 32'(rv1), 32'd0);
      tick(); req = 2'b11; addr = {BASE + 32'd28, BASE + 32'd12}; settle();
      chk("e_first_gnt", 32'(gnt0), 32'h1);
      tick(); req = 2'b00; settle();
      chk("e_first_valid", 32'(rv0), 32'h1);
      chk("e_first_rdata", rd0, word(3));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
